// File: rtl/scan_pkg.sv
// Shared types for the object-table scan path: shape codes, segment layout
// and property-word field positions.
package scan_pkg;

  localparam int unsigned PROP_W     = 115;
  localparam int unsigned SHAPE_MSB  = 113;
  localparam int unsigned STATIC_BIT = 114;
  localparam int unsigned SEG_W      = 43;

  typedef enum logic [1:0] {
    SHAPE_CIRCLE = 2'b00,
    SHAPE_RECT   = 2'b01,
    SHAPE_LINE   = 2'b10,
    SHAPE_EMPTY  = 2'b11
  } shape_e;

  typedef struct packed {
    logic        is_static;
    logic [10:0] x1;
    logic [9:0]  y1;
    logic [10:0] x2;
    logic [9:0]  y2;
  } seg_t;

endpackage

// File: rtl/object_scan_controller.sv
// Per-frame object-table walker: fetches each entry, launches the matching
// converter and streams segments downstream. Optional macro: SCAN_TIMEOUT_EN.
module object_scan_controller
  import scan_pkg::*;
#(
  parameter int unsigned NUM_OBJECTS = 16,
  parameter int unsigned ADDR_W      = $clog2(NUM_OBJECTS)
`ifdef SCAN_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              scan_start_in,
  output logic [ADDR_W-1:0] obj_addr_out,
  input  logic [PROP_W-1:0] obj_props_in,
  output logic [PROP_W-1:0] conv_props_out,
  input  logic [SEG_W-1:0]  circ_seg_in,
  input  logic [SEG_W-1:0]  line_seg_in,
  input  logic [SEG_W-1:0]  rect_seg_in,
  output logic              rect_start_out,
  input  logic              rect_busy_in,
  input  logic              rect_valid_in,
  output logic [SEG_W-1:0]  seg_out,
  output logic [ADDR_W-1:0] seg_idx_out,
  output logic              seg_valid_out,
  input  logic              seg_ready_in,
  output logic              scan_busy_out,
  output logic              scan_done_out,
  output logic [ADDR_W:0]   skip_count_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RD_WAIT, S_DISPATCH, S_RECT_WAIT, S_EMIT, S_NEXT, S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OBJECTS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [PROP_W-1:0] props_q;
  seg_t              seg_q, seg_d;
  logic [ADDR_W:0]   skip_q;
  logic              rw_first_q;
  logic              seg_load, skip_inc;
  shape_e            shape;

  assign shape = shape_e'(props_q[SHAPE_MSB -: 2]);

`ifdef SCAN_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || state_q != S_RECT_WAIT) to_cnt_q <= '0;
    else                                  to_cnt_q <= to_cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d        = state_q;
    rect_start_out = 1'b0;
    seg_load       = 1'b0;
    seg_d          = '0;
    skip_inc       = 1'b0;
    unique case (state_q)
      S_IDLE:     if (scan_start_in) state_d = S_FETCH;
      S_FETCH:    state_d = S_RD_WAIT;
      S_RD_WAIT:  state_d = S_DISPATCH;
      S_DISPATCH: begin
        unique case (shape)
          SHAPE_CIRCLE: begin seg_load = 1'b1; seg_d = seg_t'(circ_seg_in); state_d = S_EMIT; end
          SHAPE_LINE:   begin seg_load = 1'b1; seg_d = seg_t'(line_seg_in); state_d = S_EMIT; end
          SHAPE_RECT:   begin rect_start_out = 1'b1; state_d = S_RECT_WAIT; end
          SHAPE_EMPTY:  begin skip_inc = 1'b1; state_d = S_NEXT; end
        endcase
      end
      // Busy is not trusted in the first wait cycle: the converter only
      // registers the launch strobe on the edge entering this state.
      S_RECT_WAIT: begin
        if (!rw_first_q && !rect_busy_in) begin
          if (rect_valid_in) begin
            seg_load = 1'b1;
            seg_d    = seg_t'(rect_seg_in);
            state_d  = S_EMIT;
          end else begin
            skip_inc = 1'b1;
            state_d  = S_NEXT;
          end
        end
`ifdef SCAN_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          skip_inc = 1'b1;
          state_d  = S_NEXT;
        end
`endif
      end
      S_EMIT:  if (seg_ready_in) state_d = S_NEXT;
      S_NEXT:  state_d = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      props_q    <= '0;
      seg_q      <= '0;
      skip_q     <= '0;
      rw_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_first_q <= (state_q != S_RECT_WAIT) && (state_d == S_RECT_WAIT);
      if (state_q == S_IDLE && scan_start_in) begin
        idx_q  <= '0;
        skip_q <= '0;
      end
      if (state_q == S_RD_WAIT) props_q <= obj_props_in;
      if (seg_load)             seg_q   <= seg_d;
      if (skip_inc)             skip_q  <= skip_q + 1'b1;
      if (state_q == S_NEXT && idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
    end
  end

  assign obj_addr_out   = idx_q;
  assign conv_props_out = props_q;
  assign seg_out        = seg_q;
  assign seg_idx_out    = idx_q;
  assign seg_valid_out  = (state_q == S_EMIT);
  assign scan_busy_out  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign scan_done_out  = (state_q == S_DONE);
  assign skip_count_out = skip_q;

endmodule

// File: tb/tb_object_scan_controller.sv
// Self-checking bench for object_scan_controller with behavioural table RAM
// and circle/line/rect converter models.
module tb_object_scan_controller;
  import scan_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, ready;
  logic [AW-1:0]     addr, seg_idx;
  logic [PROP_W-1:0] ram_q, conv_props;
  logic [SEG_W-1:0]  circ_seg, line_seg, rect_seg, seg;
  logic              rect_start, rect_busy, rect_valid, seg_valid, busy, done;
  logic [AW:0]       skip;
  logic [PROP_W-1:0] mem [N];

  object_scan_controller #(
    .NUM_OBJECTS(N),
    .ADDR_W(AW)
`ifdef SCAN_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk_in(clk), .rst_in(rst), .scan_start_in(start),
    .obj_addr_out(addr), .obj_props_in(ram_q), .conv_props_out(conv_props),
    .circ_seg_in(circ_seg), .line_seg_in(line_seg), .rect_seg_in(rect_seg),
    .rect_start_out(rect_start), .rect_busy_in(rect_busy), .rect_valid_in(rect_valid),
    .seg_out(seg), .seg_idx_out(seg_idx), .seg_valid_out(seg_valid), .seg_ready_in(ready),
    .scan_busy_out(busy), .scan_done_out(done), .skip_count_out(skip)
  );

  // Bench props layout: payload [41:0], lat [99:96], err [100], stuck [101].
  always @(posedge clk) ram_q <= mem[addr];

  assign circ_seg = {conv_props[STATIC_BIT], conv_props[10:0] - conv_props[31:21], conv_props[20:11],
                     conv_props[10:0] + conv_props[31:21], conv_props[20:11]};
  assign line_seg = {conv_props[STATIC_BIT], conv_props[41:0]};

  logic [3:0] rcnt;
  logic       rstuck, rerr;
  always @(posedge clk) begin
    if (rst) begin
      rect_busy <= 1'b0; rect_valid <= 1'b0; rect_seg <= '0;
      rcnt <= '0; rstuck <= 1'b0; rerr <= 1'b0;
    end else if (rect_start) begin
      rect_busy <= 1'b1; rect_valid <= 1'b0;
      rcnt <= conv_props[99:96]; rerr <= conv_props[100]; rstuck <= conv_props[101];
    end else if (rect_busy && !rstuck) begin
      if (rcnt == 4'd0) begin
        rect_busy  <= 1'b0;
        rect_valid <= !rerr;
        rect_seg   <= {conv_props[STATIC_BIT], conv_props[10:0], conv_props[20:11],
                       conv_props[10:0] + conv_props[31:21], conv_props[20:11]};
      end else rcnt <= rcnt - 4'd1;
    end
  end

  typedef struct { logic [PROP_W-1:0] props; bit emit; logic [SEG_W-1:0] seg; } vec_t;
  typedef struct packed { logic [AW-1:0] idx; logic [SEG_W-1:0] seg; } out_t;

  vec_t tab [N];
  out_t exp_q [$];
  out_t obs_q [$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  function automatic logic [PROP_W-1:0] mkp(input logic [1:0] sh, input logic st, input logic [41:0] pl,
                                            input logic [3:0] lat, input logic err, input logic stuck);
    logic [PROP_W-1:0] p;
    p = '0;
    p[STATIC_BIT] = st;
    p[SHAPE_MSB -: 2] = sh;
    p[41:0] = pl;
    p[99:96] = lat;
    p[100] = err;
    p[101] = stuck;
    return p;
  endfunction

  function automatic logic [41:0] cpl(input logic [10:0] cx, input logic [9:0] cy, input logic [10:0] r);
    return {10'd0, r, cy, cx};
  endfunction

  function automatic logic [SEG_W-1:0] sg(input logic st, input logic [10:0] x1, input logic [9:0] y1,
                                          input logic [10:0] x2, input logic [9:0] y2);
    return {st, x1, y1, x2, y2};
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Samples the values that will be seen by the coming edge, then advances.
  task automatic cyc();
    if (!rst && seg_valid && ready) obs_q.push_back('{seg_idx, seg});
    if (done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic load_table();
    for (int unsigned i = 0; i < N; i++) begin
      mem[i] = tab[i].props;
      if (tab[i].emit) exp_q.push_back('{AW'(i), tab[i].seg});
    end
  endtask

  task automatic start_scan();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin cyc(); n++; end
    if (done_cnt == d0) chk({nm, "_done_timeout"}, 0, 1);
    repeat (3) cyc();
  endtask

  task automatic drain(input string nm);
    out_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        chk({nm, "_missing_seg"}, 0, {e.idx, e.seg});
      end else begin
        o = obs_q.pop_front();
        chk({nm, "_seg"}, {o.idx, o.seg}, {e.idx, e.seg});
      end
    end
    chk({nm, "_extra_segs"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic circle_table();
    for (int unsigned i = 0; i < N; i++)
      tab[i] = '{mkp(2'b00, 1'b0, cpl(11'(50 + 10 * i), 10'd30, 11'd5), 4'd0, 1'b0, 1'b0), 1'b1,
                 sg(1'b0, 11'(45 + 10 * i), 10'd30, 11'(55 + 10 * i), 10'd30)};
  endtask

  initial begin
    int k, d0;
    logic [SEG_W-1:0] held_seg;
    logic [AW-1:0]    held_idx;
    bit               stable;

    rst = 1'b1; start = 1'b0; ready = 1'b1;
    for (int unsigned i = 0; i < N; i++) mem[i] = '0;
    repeat (3) cyc();
    chk("reset_outputs", {addr, conv_props, rect_start, seg, seg_idx, seg_valid, busy, done, skip}, 0);
    rst = 1'b0;
    cyc();

    // Scan A: circle, line, empty, rect.
    tab[0] = '{mkp(2'b00, 1'b1, cpl(11'd100, 10'd50, 11'd20), 4'd0, 1'b0, 1'b0), 1'b1, sg(1'b1, 11'd80, 10'd50, 11'd120, 10'd50)};
    tab[1] = '{mkp(2'b10, 1'b0, {11'd5, 10'd6, 11'd300, 10'd400}, 4'd0, 1'b0, 1'b0), 1'b1, sg(1'b0, 11'd5, 10'd6, 11'd300, 10'd400)};
    tab[2] = '{mkp(2'b11, 1'b0, 42'd0, 4'd0, 1'b0, 1'b0), 1'b0, '0};
    tab[3] = '{mkp(2'b01, 1'b0, cpl(11'd10, 10'd20, 11'd30), 4'd3, 1'b0, 1'b0), 1'b1, sg(1'b0, 11'd10, 10'd20, 11'd40, 10'd20)};
    load_table();
    d0 = done_cnt;
    start_scan();
    chk("A_busy_after_start", busy, 1);
    k = 0;
    while (!seg_valid && k < 20) begin cyc(); k++; end
    chk("A_first_latency", k + 1, 4);
    wait_done("A", 200);
    drain("A");
    chk("A_skip", skip, 1);
    chk("A_done_pulses", done_cnt - d0, 1);
    chk("A_busy_after_done", busy, 0);

    // Scan B: backpressure on a single circle.
    tab[0] = '{mkp(2'b00, 1'b0, cpl(11'd200, 10'd100, 11'd7), 4'd0, 1'b0, 1'b0), 1'b1, sg(1'b0, 11'd193, 10'd100, 11'd207, 10'd100)};
    for (int unsigned i = 1; i < N; i++) tab[i] = '{mkp(2'b11, 1'b0, 42'd0, 4'd0, 1'b0, 1'b0), 1'b0, '0};
    load_table();
    ready = 1'b0;
    start_scan();
    k = 0;
    while (!seg_valid && k < 20) begin cyc(); k++; end
    held_seg = seg;
    held_idx = seg_idx;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (seg !== held_seg || seg_idx !== held_idx || seg_valid !== 1'b1) stable = 1'b0;
    end
    chk("B_hold_stable", stable, 1);
    chk("B_no_transfer_while_stalled", obs_q.size(), 0);
    ready = 1'b1;
    wait_done("B", 200);
    drain("B");
    chk("B_skip", skip, 3);

    // Scan C: rect divide error, then a restart attempt while busy.
    tab[0] = '{mkp(2'b01, 1'b1, cpl(11'd1, 10'd1, 11'd1), 4'd2, 1'b1, 1'b0), 1'b0, '0};
    tab[1] = '{mkp(2'b00, 1'b1, cpl(11'd300, 10'd10, 11'd10), 4'd0, 1'b0, 1'b0), 1'b1, sg(1'b1, 11'd290, 10'd10, 11'd310, 10'd10)};
    tab[2] = '{mkp(2'b10, 1'b1, {11'd1, 10'd2, 11'd3, 10'd4}, 4'd0, 1'b0, 1'b0), 1'b1, sg(1'b1, 11'd1, 10'd2, 11'd3, 10'd4)};
    tab[3] = '{mkp(2'b01, 1'b1, cpl(11'd500, 10'd300, 11'd100), 4'd0, 1'b0, 1'b0), 1'b1, sg(1'b1, 11'd500, 10'd300, 11'd600, 10'd300)};
    load_table();
    d0 = done_cnt;
    start_scan();
    repeat (12) cyc();
    start_scan();
    wait_done("C", 200);
    drain("C");
    chk("C_skip", skip, 1);
    chk("C_done_pulses", done_cnt - d0, 1);

    // Scan D: reset while waiting on a slow rect, then a clean rescan.
    tab[0] = '{mkp(2'b01, 1'b0, cpl(11'd7, 10'd7, 11'd7), 4'd15, 1'b0, 1'b0), 1'b1, '0};
    for (int unsigned i = 1; i < N; i++) tab[i] = '{mkp(2'b00, 1'b0, cpl(11'd9, 10'd9, 11'd1), 4'd0, 1'b0, 1'b0), 1'b1, '0};
    for (int unsigned i = 0; i < N; i++) mem[i] = tab[i].props;
    start_scan();
    k = 0;
    while (!rect_start && k < 20) begin cyc(); k++; end
    chk("D_rect_launched", rect_start, 1);
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    chk("D_reset_outputs", {addr, conv_props, rect_start, seg, seg_idx, seg_valid, busy, done, skip}, 0);
    rst = 1'b0;
    obs_q.delete();
    cyc();
    circle_table();
    load_table();
    start_scan();
    wait_done("D", 200);
    drain("D");
    chk("D_skip", skip, 0);

    // Scan E: rect converter stuck busy.
    circle_table();
    tab[0] = '{mkp(2'b01, 1'b0, cpl(11'd7, 10'd7, 11'd7), 4'd0, 1'b0, 1'b1), 1'b0, '0};
`ifdef SCAN_TIMEOUT_EN
    load_table();
    start_scan();
    k = 0;
    while (!rect_start && k < 20) begin cyc(); k++; end
    k = 0;
    while (addr == 2'd0 && k < 40) begin cyc(); k++; end
    chk("E_timeout_cycles", k, 10);
    wait_done("E", 200);
    drain("E");
    chk("E_skip", skip, 1);
`else
    for (int unsigned i = 0; i < N; i++) mem[i] = tab[i].props;
    d0 = done_cnt;
    start_scan();
    repeat (150) cyc();
    chk("E_still_busy", busy, 1);
    chk("E_no_done", done_cnt - d0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    obs_q.delete();
    cyc();
    chk("E_recovered_idle", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
